// File: rtl/player_motion_ctrl_if.sv
// Signal bundle between the button decoder, the wall-lookup port, the renderer and
// player_motion_ctrl. master = the controller, slave = its environment.
interface player_motion_ctrl_if #(
  parameter int COORD_W = 4
);
  // Button levels from the decoder
  logic               rotateCCW;
  logic               forward;
  logic               rotateCW;
  logic               pressed;

  // Wall lookup handshake:
  //   probe_valid rises with probe_x/probe_y and holds them stable until probe_ready
  //   is sampled high. The request completes on that edge, and probe_wall is only
  //   meaningful in that cycle. probe_ready is ignored while probe_valid is low.
  logic               probe_valid;
  logic               probe_ready;
  logic               probe_wall;
  logic [COORD_W-1:0] probe_x;
  logic [COORD_W-1:0] probe_y;

  // Player state towards the renderer
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [1:0]         dir;
  logic               update;
  logic               blocked;
  logic               busy;
  logic [1:0]         state_dbg;

  modport master (
    input  rotateCCW, forward, rotateCW, pressed, probe_ready, probe_wall,
    output probe_valid, probe_x, probe_y, pos_x, pos_y, dir, update, blocked,
           busy, state_dbg
  );

  modport slave (
    output rotateCCW, forward, rotateCW, pressed, probe_ready, probe_wall,
    input  probe_valid, probe_x, probe_y, pos_x, pos_y, dir, update, blocked,
           busy, state_dbg
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player position/direction controller: one action per button press, forward moves
// checked against map bounds and a wall-lookup handshake. Optional AUTO_REPEAT_EN
// re-executes a held single action every REPEAT_CYCLES.
module player_motion_ctrl #(
  parameter int MAP_W         = 16,
  parameter int MAP_H         = 16,
  parameter int COORD_W       = 4,
  parameter int START_X       = 1,
  parameter int START_Y       = 1,
  parameter int START_DIR     = 0,
  parameter int REPEAT_CYCLES = 25000000
) (
  input logic                 clk,
  input logic                 rst_n,
  player_motion_ctrl_if.master pm
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PROBE    = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;

  localparam logic [COORD_W-1:0] MAX_X       = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] MAX_Y       = COORD_W'(MAP_H - 1);
  localparam logic [COORD_W-1:0] START_X_C   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C   = COORD_W'(START_Y);
  localparam logic [1:0]         START_DIR_C = 2'(START_DIR);

  state_t             state_d, state_q;
  logic [COORD_W-1:0] pos_x_d, pos_x_q;
  logic [COORD_W-1:0] pos_y_d, pos_y_q;
  logic [1:0]         dir_d, dir_q;
  logic               update_d, update_q;
  logic               blocked_d, blocked_q;
  logic               probe_valid_d, probe_valid_q;
  logic [COORD_W-1:0] probe_x_d, probe_x_q;
  logic [COORD_W-1:0] probe_y_d, probe_y_q;
  logic               busy_d, busy_q;

  logic               single_act;
  logic               repeat_fire;
  logic               tgt_ok;
  logic [COORD_W-1:0] tgt_x;
  logic [COORD_W-1:0] tgt_y;

  // Three-input XOR is high for one or three set bits; exclude the all-three case.
  assign single_act = pm.pressed
                    && (pm.rotateCCW ^ pm.forward ^ pm.rotateCW)
                    && !(pm.rotateCCW && pm.forward && pm.rotateCW);

  always_comb begin
    tgt_ok = 1'b1;
    tgt_x  = pos_x_q;
    tgt_y  = pos_y_q;
    case (dir_q)
      DIR_N: begin
        if (pos_y_q == '0 || pos_y_q > MAX_Y) tgt_ok = 1'b0;
        else                                  tgt_y  = pos_y_q - 1'b1;
      end
      DIR_E: begin
        if (pos_x_q >= MAX_X) tgt_ok = 1'b0;
        else                  tgt_x  = pos_x_q + 1'b1;
      end
      DIR_S: begin
        if (pos_y_q >= MAX_Y) tgt_ok = 1'b0;
        else                  tgt_y  = pos_y_q + 1'b1;
      end
      default: begin
        if (pos_x_q == '0 || pos_x_q > MAX_X) tgt_ok = 1'b0;
        else                                  tgt_x  = pos_x_q - 1'b1;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int               CNT_W    = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Only a single held action in WAIT_REL accumulates hold time.
  always_comb begin
    repeat_fire = (state_q == S_WAIT_REL) && single_act && (cnt_q == CNT_LAST);
    cnt_d       = '0;
    if ((state_q == S_WAIT_REL) && single_act && !repeat_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign repeat_fire = 1'b0;

  // Without the repeat path the hold time only has to be sane for other builds.
  if (REPEAT_CYCLES < 1) begin : g_repeat_cycles_unused
  end
`endif

  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    dir_d         = dir_q;
    update_d      = 1'b0;
    blocked_d     = 1'b0;
    probe_valid_d = probe_valid_q;
    probe_x_d     = probe_x_q;
    probe_y_d     = probe_y_q;

    case (state_q)
      S_IDLE: begin
        if (pm.pressed) begin
          state_d = S_WAIT_REL;
          if (single_act) begin
            if (pm.rotateCW) begin
              dir_d    = dir_q + 2'd1;
              update_d = 1'b1;
            end else if (pm.rotateCCW) begin
              dir_d    = dir_q - 2'd1;
              update_d = 1'b1;
            end else if (tgt_ok) begin
              probe_x_d     = tgt_x;
              probe_y_d     = tgt_y;
              probe_valid_d = 1'b1;
              state_d       = S_PROBE;
            end else begin
              blocked_d = 1'b1;
            end
          end
        end
      end

      S_PROBE: begin
        // The pending target lives in probe_x/probe_y until the lookup answers.
        if (pm.probe_ready) begin
          probe_valid_d = 1'b0;
          state_d       = S_WAIT_REL;
          if (pm.probe_wall) begin
            blocked_d = 1'b1;
          end else begin
            pos_x_d  = probe_x_q;
            pos_y_d  = probe_y_q;
            update_d = 1'b1;
          end
        end
      end

      S_WAIT_REL: begin
        if (!pm.pressed || repeat_fire) state_d = S_IDLE;
      end

      default: begin
        state_d       = S_WAIT_REL;
        probe_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_REL;
      pos_x_q       <= START_X_C;
      pos_y_q       <= START_Y_C;
      dir_q         <= START_DIR_C;
      update_q      <= 1'b0;
      blocked_q     <= 1'b0;
      probe_valid_q <= 1'b0;
      probe_x_q     <= '0;
      probe_y_q     <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      dir_q         <= dir_d;
      update_q      <= update_d;
      blocked_q     <= blocked_d;
      probe_valid_q <= probe_valid_d;
      probe_x_q     <= probe_x_d;
      probe_y_q     <= probe_y_d;
      busy_q        <= busy_d;
    end
  end

  assign pm.pos_x       = pos_x_q;
  assign pm.pos_y       = pos_y_q;
  assign pm.dir         = dir_q;
  assign pm.update      = update_q;
  assign pm.blocked     = blocked_q;
  assign pm.probe_valid = probe_valid_q;
  assign pm.probe_x     = probe_x_q;
  assign pm.probe_y     = probe_y_q;
  assign pm.busy        = busy_q;
  assign pm.state_dbg   = state_q;

endmodule
